mine_count_scan: RTL and testbench
==================================

// Module: mine_count_scan
// PURPOSE
//  Consumer of the 25-bit mine map produced by the mine-placement RNG. Latches a
//  map on in_start, then streams one beat per cell (index, is-mine, adjacent-mine
//  count 0..8) over a valid/ready interface to the board display/reveal logic.
//  Also reports the total mine count. One cell per accepted beat, no wrap-around.
// PARAMETERS
//  ROWS  5  board rows
//  COLS  5  board columns; N = ROWS*COLS cells, cell idx = row*COLS + col
// PORTS
//  in_clka      in   1               clock; all state updates on falling edge
//  in_resetn    in   1               async active-low reset
//  in_start     in   1               start scan; sampled only in IDLE
//  in_mines     in   N               mine map, bit idx = 1 -> mine at idx
//  in_ready     in   1               downstream accepts current beat
//  out_valid    out  1               beat valid
//  out_idx      out  clog2(N)        cell index of current beat
//  out_is_mine  out  1               latched map bit at out_idx
//  out_count    out  4               mines among 8 neighbours of out_idx
//  out_total    out  clog2(N+1)      popcount of latched map
//  out_busy     out  1               1 in SCAN or DONE
//  out_done     out  1               1-cycle pulse after last beat accepted
// BEHAVIOUR
//  Clock/reset: one clock, reset is asynchronous and active-low. in_resetn=0 forces
//   IDLE, map reg=0, idx=0; all outputs 0 immediately, independent of clock.
//  FSM: IDLE -> SCAN -> DONE -> IDLE.
//   IDLE: out_valid=0, out_busy=0. Falling edge with in_start=1: latch in_mines,
//    out_total<=popcount(in_mines), idx<=0, go SCAN.
//   SCAN: out_valid=1; out_idx=idx; out_is_mine/out_count from latched map and idx.
//    Edge with in_ready=1: idx==N-1 -> DONE, else idx<=idx+1.
//    in_ready=0: idx, out_* held stable (no skip, no repeat).
//   DONE: out_valid=0, out_done=1 for exactly one cycle, then IDLE.
//  Latency: first beat visible one cycle after start sampled; N accepted beats
//   minimum N cycles; out_done one cycle after last handshake.
//  in_start ignored in SCAN/DONE; in_mines changes after latch have no effect.
//  Neighbour count: sum of map bits at (r+dr, c+dc), dr,dc in {-1,0,1}, excluding
//   (0,0); off-board neighbours contribute 0 (no row/column wrap). Computed for
//   mine cells too. Corner max 3, edge max 5, interior max 8; fits 4 bits.
//  out_total holds its value until next start latch (valid in IDLE after a scan).
//  Simultaneous in_start with DONE: ignored; start accepted next cycle in IDLE.
//  Reset mid-scan: stream aborted, no out_done; next start begins fresh at idx 0.
// TESTING
//  1 map=0, start, ready=1 -> 25 beats idx 0..24, all count 0, is_mine 0, total 0,
//    out_done pulse one cycle after idx 24 handshake.
//  2 map bit 12 only -> idx 6,7,8,11,13,16,17,18 count 1; idx 12 is_mine 1 count 0;
//    all others 0; total 1.
//  3 map all ones -> idx0 count 3, idx2 count 5, idx12 count 8, idx24 count 3,
//    every is_mine 1, total 25.
//  4 map bit 0 only -> idx 1,5,6 count 1; idx 4,20,24 count 0 (no wrap).
//  5 backpressure: ready=0 for 3 cycles while idx=4 -> out_idx/out_count stable,
//    resume at 4, exactly 25 beats total; in_start pulse mid-scan has no effect.
//  6 resetn low during SCAN at idx 10 -> outputs 0 asynchronously, no out_done;
//    new start with map bit 24 -> fresh scan from idx 0, idx 18,19,23 count 1.

Source files
------------

// File: rtl/mine_count_scan.sv
// Mine-map scanner: latches a ROWS x COLS mine map on start and streams one beat per
// cell (index, mine bit, adjacent-mine count) over valid/ready, plus the total mine count.
module mine_count_scan #(
    parameter  int ROWS = 5,
    parameter  int COLS = 5,
    localparam int N    = ROWS * COLS,
    localparam int IW   = $clog2(N),
    localparam int TW   = $clog2(N + 1)
) (
    input  logic          in_clka,
    input  logic          in_resetn,
    input  logic          in_start,
    input  logic [N-1:0]  in_mines,
    input  logic          in_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic          out_is_mine,
    output logic [3:0]    out_count,
    output logic [TW-1:0] out_total,
    output logic          out_busy,
    output logic          out_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [N-1:0]  map_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic          last_s;
    logic [TW-1:0] total_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic          is_mine_q;
    logic [3:0]    count_q;

    function automatic logic [TW-1:0] popcount(input logic [N-1:0] map);
        logic [TW-1:0] sum;
        sum = {TW{1'b0}};
        for (int i = 0; i < N; i++) begin
            sum = sum + TW'(map[i]);
        end
        return sum;
    endfunction

    // Cells are compared by row/column distance, so off-board neighbours never alias
    // onto the opposite edge.
    function automatic logic [3:0] nbr_count(input logic [N-1:0] map, input logic [IW-1:0] idx);
        logic [3:0] cnt;
        int         r;
        int         c;
        int         dr;
        int         dc;
        cnt = 4'd0;
        r   = int'(idx) / COLS;
        c   = int'(idx) % COLS;
        for (int j = 0; j < N; j++) begin
            dr = (j / COLS) - r;
            dc = (j % COLS) - c;
            if (map[j] && (j != int'(idx)) && (dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1)) begin
                cnt = cnt + 4'd1;
            end
        end
        return cnt;
    endfunction

    // Index of the next beat; holds on the last cell.
    always_comb begin
        last_s = (idx_q == IW'(N - 1));
        if (last_s) begin
            idx_d = idx_q;
        end else begin
            idx_d = idx_q + IW'(1);
        end
    end

    // Scan FSM; every output comes straight from a register updated on the falling edge.
    always_ff @(negedge in_clka or negedge in_resetn) begin
        if (!in_resetn) begin
            state_q   <= ST_IDLE;
            map_q     <= {N{1'b0}};
            idx_q     <= {IW{1'b0}};
            total_q   <= {TW{1'b0}};
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            is_mine_q <= 1'b0;
            count_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (in_start) begin
                        map_q     <= in_mines;
                        total_q   <= popcount(in_mines);
                        idx_q     <= {IW{1'b0}};
                        is_mine_q <= in_mines[0];
                        count_q   <= nbr_count(in_mines, IW'(0));
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SCAN;
                    end else begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (in_ready) begin
                        if (last_s) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q     <= idx_d;
                            is_mine_q <= map_q[idx_d];
                            count_q   <= nbr_count(map_q, idx_d);
                        end
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid   = valid_q;
    assign out_idx     = idx_q;
    assign out_is_mine = is_mine_q;
    assign out_count   = count_q;
    assign out_total   = total_q;
    assign out_busy    = busy_q;
    assign out_done    = done_q;

endmodule

// File: tb/tb_mine_count_scan.sv
// Directed self-checking bench for mine_count_scan (5x5 board, falling-edge DUT,
// outputs sampled on the rising edge).
module tb_mine_count_scan;

    logic        in_clka;
    logic        in_resetn;
    logic        in_start;
    logic [24:0] in_mines;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic        out_is_mine;
    logic [3:0]  out_count;
    logic [4:0]  out_total;
    logic        out_busy;
    logic        out_done;

    int          n_checks;
    int          n_pass;
    logic [3:0]  exp_cnt [25];

    mine_count_scan #(.ROWS(5), .COLS(5)) dut (
        .in_clka     (in_clka),
        .in_resetn   (in_resetn),
        .in_start    (in_start),
        .in_mines    (in_mines),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_is_mine (out_is_mine),
        .out_count   (out_count),
        .out_total   (out_total),
        .out_busy    (out_busy),
        .out_done    (out_done)
    );

    initial in_clka = 1'b0;
    always #5 in_clka = ~in_clka;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 25; i++) exp_cnt[i] = 4'd0;
    endtask

    task automatic set_all_ones_exp();
        exp_cnt[0]  = 4'd3; exp_cnt[1]  = 4'd5; exp_cnt[2]  = 4'd5; exp_cnt[3]  = 4'd5; exp_cnt[4]  = 4'd3;
        exp_cnt[5]  = 4'd5; exp_cnt[6]  = 4'd8; exp_cnt[7]  = 4'd8; exp_cnt[8]  = 4'd8; exp_cnt[9]  = 4'd5;
        exp_cnt[10] = 4'd5; exp_cnt[11] = 4'd8; exp_cnt[12] = 4'd8; exp_cnt[13] = 4'd8; exp_cnt[14] = 4'd5;
        exp_cnt[15] = 4'd5; exp_cnt[16] = 4'd8; exp_cnt[17] = 4'd8; exp_cnt[18] = 4'd8; exp_cnt[19] = 4'd5;
        exp_cnt[20] = 4'd3; exp_cnt[21] = 4'd5; exp_cnt[22] = 4'd5; exp_cnt[23] = 4'd5; exp_cnt[24] = 4'd3;
    endtask

    // Runs one scan; stall_idx holds ready low for 3 cycles at that beat (with a start
    // pulse in the middle), abort_idx returns as soon as that beat is visible.
    task automatic run_scan(input int tn, input logic [24:0] map, input int exp_total,
                            input int stall_idx, input int abort_idx, input bit start_in_done);
        int beat;
        int stalls;
        int guard;
        beat   = 0;
        stalls = 0;
        guard  = 0;
        @(posedge in_clka);
        in_mines = map;
        in_start = 1'b1;
        in_ready = 1'b0;
        while (beat < 25 && guard < 100) begin
            @(posedge in_clka);
            guard++;
            if (guard == 1) begin
                in_start = 1'b0;
                in_mines = ~map;
            end
            check($sformatf("t%0d valid b%0d", tn, beat), out_valid, 1);
            check($sformatf("t%0d idx b%0d", tn, beat), out_idx, beat);
            check($sformatf("t%0d is_mine b%0d", tn, beat), out_is_mine, map[beat]);
            check($sformatf("t%0d count b%0d", tn, beat), out_count, exp_cnt[beat]);
            if (beat == abort_idx) return;
            if (beat == stall_idx && stalls < 3) begin
                in_ready = 1'b0;
                stalls++;
                in_start = (stalls == 2);
            end else begin
                in_ready = 1'b1;
                in_start = 1'b0;
                beat++;
            end
        end
        check($sformatf("t%0d beats", tn), beat, 25);
        @(posedge in_clka);
        in_ready = 1'b0;
        check($sformatf("t%0d done_valid", tn), out_valid, 0);
        check($sformatf("t%0d done_pulse", tn), out_done, 1);
        check($sformatf("t%0d done_busy", tn), out_busy, 1);
        check($sformatf("t%0d total", tn), out_total, exp_total);
        if (start_in_done) begin
            in_start = 1'b1;
            in_mines = 25'h1555555;
        end
        @(posedge in_clka);
        in_start = 1'b0;
        check($sformatf("t%0d post_done", tn), out_done, 0);
        check($sformatf("t%0d post_valid", tn), out_valid, 0);
        check($sformatf("t%0d post_busy", tn), out_busy, 0);
        check($sformatf("t%0d total_held", tn), out_total, exp_total);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        in_resetn = 1'b0;
        in_start  = 1'b0;
        in_mines  = 25'h0;
        in_ready  = 1'b0;
        #3;
        check("rst valid", out_valid, 0);
        check("rst idx", out_idx, 0);
        check("rst count", out_count, 0);
        check("rst total", out_total, 0);
        check("rst busy", out_busy, 0);
        check("rst done", out_done, 0);
        repeat (2) @(posedge in_clka);
        in_resetn = 1'b1;

        clear_exp();
        run_scan(1, 25'h0, 0, -1, -1, 1'b0);

        clear_exp();
        exp_cnt[6] = 4'd1; exp_cnt[7] = 4'd1; exp_cnt[8] = 4'd1; exp_cnt[11] = 4'd1;
        exp_cnt[13] = 4'd1; exp_cnt[16] = 4'd1; exp_cnt[17] = 4'd1; exp_cnt[18] = 4'd1;
        run_scan(2, 25'h0001000, 1, -1, -1, 1'b0);

        set_all_ones_exp();
        run_scan(3, 25'h1FFFFFF, 25, -1, -1, 1'b0);

        clear_exp();
        exp_cnt[1] = 4'd1; exp_cnt[5] = 4'd1; exp_cnt[6] = 4'd1;
        run_scan(4, 25'h0000001, 1, -1, -1, 1'b1);

        set_all_ones_exp();
        run_scan(5, 25'h1FFFFFF, 25, 4, -1, 1'b0);

        run_scan(6, 25'h1FFFFFF, 25, -1, 10, 1'b0);
        #2;
        in_resetn = 1'b0;
        #1;
        check("t6 abort valid", out_valid, 0);
        check("t6 abort idx", out_idx, 0);
        check("t6 abort is_mine", out_is_mine, 0);
        check("t6 abort count", out_count, 0);
        check("t6 abort total", out_total, 0);
        check("t6 abort busy", out_busy, 0);
        @(posedge in_clka);
        in_resetn = 1'b1;
        in_ready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge in_clka);
            check($sformatf("t6 no_done c%0d", k), out_done, 0);
        end
        clear_exp();
        exp_cnt[18] = 4'd1; exp_cnt[19] = 4'd1; exp_cnt[23] = 4'd1;
        run_scan(7, 25'h1000000, 1, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
